// File: rtl/wb_regfile.sv
// wb_regfile -- architectural register file, receiving end of the WB-to-RF bus.
//
// Holds 32 GPRs (index 0 hard-wired to zero) plus a HI/LO pair. The GPRs have
// two combinational read ports with same-cycle write-through bypass. HI/LO
// have an independent write port and bypass their pending write data.
//
// Ports:
//   clk          core clock, all state updates on the rising edge
//   resetn       asynchronous active-low reset, clears GPRs, HI and LO
//   wb_to_rf_bus {we, waddr[ADDR_W-1:0], wdata[DATA_W-1:0]} from WB
//   hilo_we      bit1 writes HI, bit0 writes LO
//   hi_wdata     HI write data
//   lo_wdata     LO write data
//   raddr1/2     read port indices
//   rdata1/2     read port data (combinational, bypassed)
//   hi_rdata     HI value including bypass
//   lo_rdata     LO value including bypass
//
// Optional build macro WB_REGFILE_TRACE_EN adds commit tracing outputs:
//   commit_cnt   number of committed GPR writes (waddr != 0), wraps
//   last_wnum    index of the last committed GPR write
//   last_wdata   data of the last committed GPR write
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BUS_W  = 1 + ADDR_W + DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [BUS_W-1:0]  wb_to_rf_bus,
    input  logic [1:0]        hilo_we,
    input  logic [DATA_W-1:0] hi_wdata,
    input  logic [DATA_W-1:0] lo_wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_rdata,
    output logic [DATA_W-1:0] lo_rdata
`ifdef WB_REGFILE_TRACE_EN
    ,
    output logic [31:0]       commit_cnt,
    output logic [ADDR_W-1:0] last_wnum,
    output logic [DATA_W-1:0] last_wdata
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              commit;

    assign we     = wb_to_rf_bus[BUS_W-1];
    assign waddr  = wb_to_rf_bus[DATA_W +: ADDR_W];
    assign wdata  = wb_to_rf_bus[DATA_W-1:0];
    // The && short-circuits an X waddr when we=0, so bubbles never write.
    assign commit = we && (waddr != '0);

    // Read mux: index 0 and reset force zero, then bypass, then stored value.
    function automatic logic [DATA_W-1:0] rd_sel(
        input logic              rst_ok,
        input logic [ADDR_W-1:0] ra,
        input logic              w_en,
        input logic [ADDR_W-1:0] w_addr,
        input logic [DATA_W-1:0] w_data,
        input logic [DATA_W-1:0] stored
    );
        if (!rst_ok || ra == '0)
            return '0;
        else if (w_en && w_addr == ra)
            return w_data;
        else
            return stored;
    endfunction

    // ---------------- GPR array ----------------
    // Entry 0 is reset and never written (commit excludes waddr 0).
    logic [DATA_W-1:0] gpr_q [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++)
                gpr_q[i] <= '0;
        end else if (commit) begin
            gpr_q[waddr] <= wdata;
        end
    end

    assign rdata1 = rd_sel(resetn, raddr1, we, waddr, wdata, gpr_q[raddr1]);
    assign rdata2 = rd_sel(resetn, raddr2, we, waddr, wdata, gpr_q[raddr2]);

    // ---------------- HI/LO pair ----------------
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hilo_we[1] ? hi_wdata : hi_q;
        lo_d = hilo_we[0] ? lo_wdata : lo_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // The next-state value is exactly the bypassed read value.
    assign hi_rdata = resetn ? hi_d : '0;
    assign lo_rdata = resetn ? lo_d : '0;

`ifdef WB_REGFILE_TRACE_EN
    // ---------------- Commit trace ----------------
    logic [31:0]       commit_cnt_q, commit_cnt_d;
    logic [ADDR_W-1:0] last_wnum_q,  last_wnum_d;
    logic [DATA_W-1:0] last_wdata_q, last_wdata_d;

    always_comb begin
        commit_cnt_d = commit_cnt_q;
        last_wnum_d  = last_wnum_q;
        last_wdata_d = last_wdata_q;
        if (commit) begin
            commit_cnt_d = commit_cnt_q + 32'd1;   // wraps naturally
            last_wnum_d  = waddr;
            last_wdata_d = wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            commit_cnt_q <= '0;
            last_wnum_q  <= '0;
            last_wdata_q <= '0;
        end else begin
            commit_cnt_q <= commit_cnt_d;
            last_wnum_q  <= last_wnum_d;
            last_wdata_q <= last_wdata_d;
        end
    end

    assign commit_cnt = commit_cnt_q;
    assign last_wnum  = last_wnum_q;
    assign last_wdata = last_wdata_q;
`endif

endmodule
